// File: rtl/demux4_16b_reg_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer and its lanes.
package demux4_16b_reg_pkg;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    localparam int unsigned LANES = 4;

endpackage

// File: rtl/demux4_16b_reg_lane.sv
// One demux output lane: data register plus EMPTY/FULL handshake state.
module demux_lane
    import demux4_16b_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] d,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    lane_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) state <= LANE_EMPTY;
        else       state <= state_next;
    end

    // Data is only ever replaced by a write; a drain leaves it in place.
    always_ff @(posedge clk) begin
        if (reset)   q <= RESET_VAL;
        else if (wr) q <= d;
    end

    always_comb begin
        state_next = state;
        case (state)
            LANE_EMPTY: if (wr)         state_next = LANE_FULL;
            LANE_FULL:  if (!wr && ack) state_next = LANE_EMPTY;
            default:                    state_next = LANE_EMPTY;
        endcase
    end

    assign valid = (state == LANE_FULL);

endmodule

// File: rtl/demux4_16b_reg.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ack handshake.
// Optional broadcast write enabled by defining DEMUX_BROADCAST_EN.
module demux4_16b_reg
    import demux4_16b_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       sel,
    input  logic             in_valid,
`ifdef DEMUX_BROADCAST_EN
    input  logic             bcast,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [3:0]       o_valid,
    input  logic [3:0]       o_ack
);

    logic             bcast_i;
    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] wr;
    logic             fire;
    logic [WIDTH-1:0] q [LANES];

`ifdef DEMUX_BROADCAST_EN
    assign bcast_i = bcast;
`else
    assign bcast_i = 1'b0;
`endif

    // A lane can accept if it is empty or is being drained this cycle.
    assign lane_ready = ~o_valid | o_ack;
    assign in_ready   = bcast_i ? (&lane_ready) : lane_ready[sel];
    assign fire       = in_valid & in_ready;

    always_comb begin
        wr = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            wr[n] = fire & (bcast_i | (sel == 2'(n)));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        demux_lane #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[g]),
            .d     (a),
            .ack   (o_ack[g]),
            .q     (q[g]),
            .valid (o_valid[g])
        );
    end

    assign o0 = q[0];
    assign o1 = q[1];
    assign o2 = q[2];
    assign o3 = q[3];

endmodule
